peek_poke_bundle_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one bundle channel between two producers.
- Bundle fields: aUInt4, aSInt5, aBundle_aBool, aBottomBool.
- Each side uses a valid/ready handshake.
- The winning bundle is captured in a one-entry output register, tagged with its source, and counted per requester.
- Sits in front of the bundle passthrough datapath so that two test drivers can poke it without collisions.

---
 rtl/peek_poke_bundle_arbiter.sv | 97 +++++++++
 tb/tb_peek_poke_bundle_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/peek_poke_bundle_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry bundle output register.
// The held bundle is tagged with the index of its source requester. A saturating
// counter per requester records how many of its bundles were accepted.
module peek_poke_bundle_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in0_valid,
    output logic             io_in0_ready,
    input  logic [3:0]       io_in0_aUInt4,
    input  logic [4:0]       io_in0_aSInt5,
    input  logic             io_in0_aBundle_aBool,
    input  logic             io_in0_aBottomBool,
    input  logic             io_in1_valid,
    output logic             io_in1_ready,
    input  logic [3:0]       io_in1_aUInt4,
    input  logic [4:0]       io_in1_aSInt5,
    input  logic             io_in1_aBundle_aBool,
    input  logic             io_in1_aBottomBool,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [3:0]       io_out_aUInt4,
    output logic [4:0]       io_out_aSInt5,
    output logic             io_out_aBundle_aBool,
    output logic             io_out_aBottomBool,
    output logic             io_out_src,
    output logic [CNT_W-1:0] io_grantCount0,
    output logic [CNT_W-1:0] io_grantCount1
);

    logic last_grant;
    logic slot_free;
    logic grant0;
    logic grant1;
    logic accept0;
    logic accept1;

    // Round-robin grant and handshake decode; the slot can refill while it drains.
    // Readies are held low during reset so that no handshake completes in a reset cycle.
    always_comb begin
        slot_free    = !io_out_valid || io_out_ready;
        grant0       = io_in0_valid && (!io_in1_valid || last_grant);
        grant1       = io_in1_valid && (!io_in0_valid || !last_grant);
        io_in0_ready = !reset && slot_free && grant0;
        io_in1_ready = !reset && slot_free && grant1;
        accept0      = io_in0_valid && io_in0_ready;
        accept1      = io_in1_valid && io_in1_ready;
    end

    // Output register: load on acceptance, clear valid on drain; data is held otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_out_valid         <= 1'b0;
            io_out_aUInt4        <= '0;
            io_out_aSInt5        <= '0;
            io_out_aBundle_aBool <= 1'b0;
            io_out_aBottomBool   <= 1'b0;
            io_out_src           <= 1'b0;
            last_grant           <= 1'b1;
        end else if (accept0) begin
            io_out_valid         <= 1'b1;
            io_out_aUInt4        <= io_in0_aUInt4;
            io_out_aSInt5        <= io_in0_aSInt5;
            io_out_aBundle_aBool <= io_in0_aBundle_aBool;
            io_out_aBottomBool   <= io_in0_aBottomBool;
            io_out_src           <= 1'b0;
            last_grant           <= 1'b0;
        end else if (accept1) begin
            io_out_valid         <= 1'b1;
            io_out_aUInt4        <= io_in1_aUInt4;
            io_out_aSInt5        <= io_in1_aSInt5;
            io_out_aBundle_aBool <= io_in1_aBundle_aBool;
            io_out_aBottomBool   <= io_in1_aBottomBool;
            io_out_src           <= 1'b1;
            last_grant           <= 1'b1;
        end else if (io_out_ready) begin
            io_out_valid         <= 1'b0;
        end
    end

    // Saturating per-requester acceptance counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_grantCount0 <= '0;
            io_grantCount1 <= '0;
        end else begin
            if (accept0 && (io_grantCount0 != '1)) begin
                io_grantCount0 <= io_grantCount0 + 1'b1;
            end
            if (accept1 && (io_grantCount1 != '1)) begin
                io_grantCount1 <= io_grantCount1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_peek_poke_bundle_arbiter.sv
// Scoreboard bench for peek_poke_bundle_arbiter: stimulus pushes the expected
// {src, bundle} for each acceptance it anticipates; a monitor pops and compares
// whenever the output register is drained.
module tb_peek_poke_bundle_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in0_valid = 1'b0, in1_valid = 1'b0;
    logic       in0_ready, in1_ready;
    logic [3:0] in0_u4 = '0, in1_u4 = '0;
    logic [4:0] in0_s5 = '0, in1_s5 = '0;
    logic       in0_b = 1'b0, in1_b = 1'b0;
    logic       in0_bb = 1'b0, in1_bb = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_u4;
    logic [4:0] out_s5;
    logic       out_b, out_bb, out_src;
    logic [7:0] cnt0, cnt1;

    int vectors = 0;
    int miscompares = 0;
    logic [11:0] sb[$];

    peek_poke_bundle_arbiter #(.CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .io_in0_valid(in0_valid), .io_in0_ready(in0_ready),
        .io_in0_aUInt4(in0_u4), .io_in0_aSInt5(in0_s5),
        .io_in0_aBundle_aBool(in0_b), .io_in0_aBottomBool(in0_bb),
        .io_in1_valid(in1_valid), .io_in1_ready(in1_ready),
        .io_in1_aUInt4(in1_u4), .io_in1_aSInt5(in1_s5),
        .io_in1_aBundle_aBool(in1_b), .io_in1_aBottomBool(in1_bb),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_aUInt4(out_u4), .io_out_aSInt5(out_s5),
        .io_out_aBundle_aBool(out_b), .io_out_aBottomBool(out_bb),
        .io_out_src(out_src),
        .io_grantCount0(cnt0), .io_grantCount1(cnt1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every drained bundle must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {4'h0, out_src, out_u4, out_s5, out_b, out_bb}, 16'hFFFF);
            end else begin
                chk("out_bundle", {4'h0, out_src, out_u4, out_s5, out_b, out_bb},
                    {4'h0, sb.pop_front()});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

    // One cycle: drive inputs, record anticipated acceptances, check readies.
    task automatic cyc(input logic v0, input logic [10:0] d0,
                       input logic v1, input logic [10:0] d1,
                       input logic ordy, input logic er0, input logic er1);
        in0_valid = v0; {in0_u4, in0_s5, in0_b, in0_bb} = d0;
        in1_valid = v1; {in1_u4, in1_s5, in1_b, in1_bb} = d1;
        out_ready = ordy;
        if (er0) sb.push_back({1'b0, d0});
        if (er1) sb.push_back({1'b1, d1});
        @(negedge clock);
        chk("in0_ready", {15'd0, in0_ready}, {15'd0, er0});
        chk("in1_ready", {15'd0, in1_ready}, {15'd0, er1});
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        sb.delete();
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_fields", {4'h0, out_src, out_u4, out_s5, out_b, out_bb}, 16'd0);
        chk("rst_counts", {cnt0, cnt1}, 16'd0);
        reset = 1'b0;
    endtask

    localparam logic [10:0] IDLE = 11'd0;

    initial begin
        logic [10:0] d;
        #1;
        do_reset(2);

        // Test 1: single in0 bundle, visible next cycle
        d = {4'hA, 5'b11101, 1'b1, 1'b0};
        cyc(1, d, 0, IDLE, 1, 1, 0);
        chk("t1_out_valid", {15'd0, out_valid}, 16'd1);
        chk("t1_out_s5", {11'd0, out_s5}, 16'h001D);
        chk("t1_cnt0", {8'd0, cnt0}, 16'd1);
        cyc(0, IDLE, 0, IDLE, 1, 0, 0);
        chk("t1_drained", {15'd0, out_valid}, 16'd0);

        // Test 2: continuous contention alternates 0,1,0,1,0,1 from reset
        do_reset(2);
        for (int k = 0; k < 6; k++) begin
            cyc(1, {4'(k), 5'(k), 2'b01}, 1, {4'(k + 8), 5'(-k - 1), 2'b10}, 1,
                (k % 2) == 0, (k % 2) == 1);
        end
        cyc(0, IDLE, 0, IDLE, 1, 0, 0);
        chk("t2_cnt0", {8'd0, cnt0}, 16'd3);
        chk("t2_cnt1", {8'd0, cnt1}, 16'd3);

        // Test 3: back-pressure holds a -16 bundle from in1; in0 wins on release
        cyc(0, IDLE, 1, {4'h5, 5'b10000, 2'b11}, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 11'h123, 1, 11'h456, 0, 0, 0);
            chk("t3_hold_s5", {11'd0, out_s5}, 16'h0010);
            chk("t3_hold_src", {15'd0, out_src}, 16'd1);
            chk("t3_hold_valid", {15'd0, out_valid}, 16'd1);
        end
        cyc(1, 11'h123, 1, 11'h456, 1, 1, 0);

        // Test 4: same-cycle drain and refill from in1, no bubble
        cyc(0, IDLE, 1, {4'h3, 5'b01111, 2'b01}, 1, 0, 1);
        chk("t4_no_bubble", {15'd0, out_valid}, 16'd1);
        chk("t4_src", {15'd0, out_src}, 16'd1);
        cyc(0, IDLE, 0, IDLE, 1, 0, 0);

        // Test 5: reset while holding with counts 5/7 and last_grant=0
        do_reset(1);
        for (int k = 0; k < 7; k++) cyc(0, IDLE, 1, 11'(k + 32), 1, 0, 1);
        for (int k = 0; k < 5; k++) cyc(1, 11'(k + 64), 0, IDLE, 1, 1, 0);
        cyc(0, IDLE, 0, IDLE, 0, 0, 0);
        chk("t5_cnt0", {8'd0, cnt0}, 16'd5);
        chk("t5_cnt1", {8'd0, cnt1}, 16'd7);
        chk("t5_held", {15'd0, out_valid}, 16'd1);
        do_reset(1);
        cyc(1, 11'h2AA, 1, 11'h155, 1, 1, 0);
        cyc(0, IDLE, 0, IDLE, 1, 0, 0);

        // Test 6: saturation of the in0 counter
        do_reset(1);
        for (int k = 0; k < 260; k++) begin
            cyc(1, 11'(k), 0, IDLE, 1, 1, 0);
            if (k == 254) chk("t6_reach_max", {8'd0, cnt0}, 16'd255);
        end
        cyc(0, IDLE, 0, IDLE, 1, 0, 0);
        chk("t6_cnt0_sat", {8'd0, cnt0}, 16'd255);
        chk("t6_cnt1", {8'd0, cnt1}, 16'd0);

        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
